// File: rtl/seg_scan_controller.sv
// Multiplexed 7-segment scan controller: blank/show slot sequencing per digit, optional
// leading-zero suppression, and a double-buffered display that only changes at frame end.
module seg_scan_controller #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned PRESCALE     = 1000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    LOAD,
    input  logic [4*NUM_DIGITS-1:0] DATA_IN,
    input  logic                    LZ_EN,
    output logic [3:0]              SEG_VAL,
    output logic [NUM_DIGITS-1:0]   DIG_EN,
    output logic                    LOAD_PENDING,
    output logic                    FRAME_DONE
);

    localparam int unsigned CntMax = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax);
    localparam int unsigned IdxW   = $clog2(NUM_DIGITS);

    localparam logic [3:0]      CodeBlank = 4'hA;
    localparam logic [CntW-1:0] ShowLast  = CntW'(PRESCALE - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

    typedef enum logic {StBlank, StShow} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic                    supp_q, supp_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pending_q, pending_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;
    logic                    frame_done_q;
    logic                    frame_end;

    logic [3:0]              code [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   zero_above;
    logic                    all_zero;

    // zero_above[i]: digits NUM_DIGITS-1..i are all zero; bit 0 stays clear so digit 0 always shows
    always_comb begin
        all_zero   = 1'b1;
        zero_above = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            code[i] = disp_q[4*i +: 4];
        end
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            all_zero      = all_zero & (disp_q[4*i +: 4] == 4'h0);
            zero_above[i] = all_zero;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        supp_d    = supp_q;
        frame_end = 1'b0;
        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StShow;
                    cnt_d   = '0;
                    // Suppression is frozen at SHOW entry so a mid-slot LZ_EN change cannot glitch
                    supp_d  = LZ_EN & zero_above[idx_q];
                end
            end
            StShow: begin
                if (cnt_q == ShowLast) begin
                    state_d   = StBlank;
                    cnt_d     = '0;
                    frame_end = (idx_q == IdxLast);
                    idx_d     = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = StBlank;
            end
        endcase
    end

    always_comb begin
        disp_d    = disp_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        if (frame_end) begin
            if (LOAD) begin
                disp_d = DATA_IN;
            end else if (pending_q) begin
                disp_d = pend_q;
            end
            pending_d = 1'b0;
        end else if (LOAD) begin
            pend_d    = DATA_IN;
            pending_d = 1'b1;
        end
    end

    // Enable is registered one cycle behind SEG_VAL to line up with the decoder's output register
    always_comb begin
        dig_en_d = '0;
        if (state_q == StShow && !supp_q) begin
            dig_en_d = NUM_DIGITS'(1) << idx_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q      <= StBlank;
            cnt_q        <= '0;
            idx_q        <= '0;
            supp_q       <= 1'b0;
            disp_q       <= {NUM_DIGITS{CodeBlank}};
            pend_q       <= '0;
            pending_q    <= 1'b0;
            dig_en_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            supp_q       <= supp_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pending_q    <= pending_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_end;
        end
    end

    assign SEG_VAL      = (state_q == StShow && !supp_q) ? code[idx_q] : CodeBlank;
    assign DIG_EN       = dig_en_q;
    assign LOAD_PENDING = pending_q;
    assign FRAME_DONE   = frame_done_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed scenarios plus a randomized run against a
// slot-arithmetic reference model (4 digits, 8-cycle show, 2-cycle blank).
module tb_seg_scan_controller;

    localparam int N     = 4;
    localparam int PRE   = 8;
    localparam int BLK   = 2;
    localparam int SLOT  = PRE + BLK;
    localparam int FRAME = N * SLOT;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        LOAD;
    logic [15:0] DATA_IN;
    logic        LZ_EN;
    logic [3:0]  SEG_VAL;
    logic [3:0]  DIG_EN;
    logic        LOAD_PENDING;
    logic        FRAME_DONE;

    int checks = 0;
    int errors = 0;

    // Reference model: m_t counts cycles since the last reset edge
    int          m_t;
    logic [3:0]  m_disp [N];
    logic [15:0] m_pend;
    logic        m_pending;
    logic        m_supp;
    logic        m_fd;
    logic [3:0]  m_dig;
    logic        lz_lvl;

    seg_scan_controller #(
        .NUM_DIGITS  (N),
        .PRESCALE    (PRE),
        .BLANK_CYCLES(BLK)
    ) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .LOAD        (LOAD),
        .DATA_IN     (DATA_IN),
        .LZ_EN       (LZ_EN),
        .SEG_VAL     (SEG_VAL),
        .DIG_EN      (DIG_EN),
        .LOAD_PENDING(LOAD_PENDING),
        .FRAME_DONE  (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] exp_seg();
        int ph;
        int dg;
        ph = m_t % SLOT;
        dg = (m_t % FRAME) / SLOT;
        if (ph >= BLK && !m_supp) return m_disp[dg];
        return 4'hA;
    endfunction

    // Apply inputs for one cycle, advance the model across the edge, return at the next negedge
    task automatic drive_cycle(input logic rstn, input logic ld, input logic [15:0] data,
                               input logic lz);
        int   ph;
        int   dg;
        logic show;
        logic fe;
        logic allz;
        RSTN    = rstn;
        LOAD    = ld;
        DATA_IN = data;
        LZ_EN   = lz;
        if (!rstn) begin
            m_t = 0;
            for (int i = 0; i < N; i++) m_disp[i] = 4'hA;
            m_pend    = '0;
            m_pending = 1'b0;
            m_supp    = 1'b0;
            m_fd      = 1'b0;
            m_dig     = '0;
        end else begin
            ph    = m_t % SLOT;
            dg    = (m_t % FRAME) / SLOT;
            show  = (ph >= BLK);
            m_dig = (show && !m_supp) ? 4'(1 << dg) : 4'b0;
            fe    = ((m_t % FRAME) == FRAME - 1);
            m_fd  = fe;
            if (fe) begin
                if (ld) begin
                    for (int i = 0; i < N; i++) m_disp[i] = data[4*i +: 4];
                end else if (m_pending) begin
                    for (int i = 0; i < N; i++) m_disp[i] = m_pend[4*i +: 4];
                end
                m_pending = 1'b0;
            end else if (ld) begin
                m_pend    = data;
                m_pending = 1'b1;
            end
            if (ph == BLK - 1) begin
                allz = 1'b1;
                for (int i = dg; i < N; i++) if (m_disp[i] != 4'h0) allz = 1'b0;
                m_supp = lz && (dg > 0) && allz;
            end
            m_t++;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic goto_pos(input int p);
        int guard;
        guard = 0;
        while ((m_t % FRAME) != p && guard < 2 * FRAME) begin
            drive_cycle(1'b1, 1'b0, 16'($urandom), lz_lvl);
            guard++;
        end
    endtask

    task automatic test_reset();
        lz_lvl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b0, 1'b1, 16'h5555, 1'b0);
            checks++;
            if (SEG_VAL !== 4'hA || DIG_EN !== 4'b0000 || LOAD_PENDING !== 1'b0 ||
                FRAME_DONE !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: seg=%h dig=%b pend=%b fd=%b, required a 0000 0 0",
                         SEG_VAL, DIG_EN, LOAD_PENDING, FRAME_DONE);
            end
        end
        for (int c = 0; c <= 41; c++) begin
            int         q;
            logic [3:0] want_dig;
            want_dig = 4'b0000;
            if (c > 0) begin
                q = (c - 1) % FRAME;
                if (q % SLOT >= BLK) want_dig = 4'(1 << (q / SLOT));
            end
            checks++;
            if (SEG_VAL !== 4'hA || DIG_EN !== want_dig || FRAME_DONE !== (c == 40) ||
                LOAD_PENDING !== 1'b0) begin
                errors++;
                $display("FAIL reset_release c=%0d: seg=%h dig=%b fd=%b pend=%b, required a %b %b 0",
                         c, SEG_VAL, DIG_EN, FRAME_DONE, LOAD_PENDING, want_dig, (c == 40));
            end
            drive_cycle(1'b1, 1'b0, 16'h0, 1'b0);
        end
    endtask

    task automatic test_load_basic();
        logic [15:0] v;
        v      = 16'h1234;
        lz_lvl = 1'b0;
        goto_pos(7);
        drive_cycle(1'b1, 1'b1, v, lz_lvl);
        for (int p = 8; p < FRAME; p++) begin
            checks++;
            if (LOAD_PENDING !== 1'b1) begin
                errors++;
                $display("FAIL load_pending p=%0d: got %b, required 1", p, LOAD_PENDING);
            end
            drive_cycle(1'b1, 1'b0, 16'h0, lz_lvl);
        end
        checks++;
        if (LOAD_PENDING !== 1'b0 || FRAME_DONE !== 1'b1) begin
            errors++;
            $display("FAIL load_commit: pend=%b fd=%b, required 0 1", LOAD_PENDING, FRAME_DONE);
        end
        for (int p = 0; p < FRAME; p++) begin
            int         q;
            logic [3:0] want_seg;
            logic [3:0] want_dig;
            want_seg = (p % SLOT >= BLK) ? v[4*(p/SLOT) +: 4] : 4'hA;
            q        = (p + FRAME - 1) % FRAME;
            want_dig = (q % SLOT >= BLK) ? 4'(1 << (q / SLOT)) : 4'b0000;
            checks++;
            if (SEG_VAL !== want_seg || DIG_EN !== want_dig) begin
                errors++;
                $display("FAIL load_frame p=%0d: seg=%h dig=%b, required %h %b",
                         p, SEG_VAL, DIG_EN, want_seg, want_dig);
            end
            drive_cycle(1'b1, 1'b0, 16'h0, lz_lvl);
        end
    endtask

    task automatic test_lz();
        logic [15:0] v;
        logic [3:0]  want_seg;
        logic [3:0]  want_dig;
        lz_lvl = 1'b1;
        v      = 16'h0050;
        goto_pos(12);
        drive_cycle(1'b1, 1'b1, v, lz_lvl);
        goto_pos(0);
        for (int d = 0; d < N; d++) begin
            goto_pos(d * SLOT + 5);
            want_seg = (d >= 2) ? 4'hA : v[4*d +: 4];
            want_dig = (d < 2) ? 4'(1 << d) : 4'b0000;
            checks++;
            if (SEG_VAL !== want_seg || DIG_EN !== want_dig) begin
                errors++;
                $display("FAIL lz_0050 d=%0d: seg=%h dig=%b, required %h %b",
                         d, SEG_VAL, DIG_EN, want_seg, want_dig);
            end
        end
        goto_pos(12);
        drive_cycle(1'b1, 1'b1, 16'h0000, lz_lvl);
        goto_pos(0);
        for (int d = 0; d < N; d++) begin
            goto_pos(d * SLOT + 5);
            want_seg = (d == 0) ? 4'h0 : 4'hA;
            want_dig = (d == 0) ? 4'b0001 : 4'b0000;
            checks++;
            if (SEG_VAL !== want_seg || DIG_EN !== want_dig) begin
                errors++;
                $display("FAIL lz_0000 d=%0d: seg=%h dig=%b, required %h %b",
                         d, SEG_VAL, DIG_EN, want_seg, want_dig);
            end
        end
    endtask

    task automatic test_no_tear();
        logic [3:0] want_seg;
        lz_lvl = 1'b0;
        goto_pos(0);
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < FRAME; p++) begin
                want_seg = (p % SLOT >= BLK) ? ((f == 0) ? 4'h0 : 4'h2) : 4'hA;
                checks++;
                if (SEG_VAL !== want_seg) begin
                    errors++;
                    $display("FAIL no_tear f=%0d p=%0d: seg=%h, required %h",
                             f, p, SEG_VAL, want_seg);
                end
                if (f == 0 && p == 5) drive_cycle(1'b1, 1'b1, 16'h1111, lz_lvl);
                else if (f == 0 && p == 20) drive_cycle(1'b1, 1'b1, 16'h2222, lz_lvl);
                else drive_cycle(1'b1, 1'b0, 16'h0, lz_lvl);
            end
        end
    endtask

    task automatic test_frame_end_load();
        logic [15:0] v;
        v      = 16'h9876;
        lz_lvl = 1'b0;
        goto_pos(10);
        drive_cycle(1'b1, 1'b1, 16'h1111, lz_lvl);
        goto_pos(FRAME - 1);
        checks++;
        if (LOAD_PENDING !== 1'b1) begin
            errors++;
            $display("FAIL edge_load_pre: pend=%b, required 1", LOAD_PENDING);
        end
        drive_cycle(1'b1, 1'b1, v, lz_lvl);
        checks++;
        if (LOAD_PENDING !== 1'b0 || FRAME_DONE !== 1'b1) begin
            errors++;
            $display("FAIL edge_load_post: pend=%b fd=%b, required 0 1", LOAD_PENDING, FRAME_DONE);
        end
        for (int d = 0; d < N; d++) begin
            goto_pos(d * SLOT + 5);
            checks++;
            if (SEG_VAL !== v[4*d +: 4] || DIG_EN !== 4'(1 << d)) begin
                errors++;
                $display("FAIL edge_load d=%0d: seg=%h dig=%b, required %h %b",
                         d, SEG_VAL, DIG_EN, v[4*d +: 4], 4'(1 << d));
            end
        end
    endtask

    task automatic test_reset_mid();
        lz_lvl = 1'b0;
        goto_pos(25);
        drive_cycle(1'b1, 1'b1, 16'h4321, lz_lvl);
        checks++;
        if (LOAD_PENDING !== 1'b1 || SEG_VAL !== 4'h8 || DIG_EN !== 4'b0100) begin
            errors++;
            $display("FAIL mid_pre: pend=%b seg=%h dig=%b, required 1 8 0100",
                     LOAD_PENDING, SEG_VAL, DIG_EN);
        end
        drive_cycle(1'b0, 1'b0, 16'h0, lz_lvl);
        checks++;
        if (SEG_VAL !== 4'hA || DIG_EN !== 4'b0000 || LOAD_PENDING !== 1'b0 ||
            FRAME_DONE !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: seg=%h dig=%b pend=%b fd=%b, required a 0000 0 0",
                     SEG_VAL, DIG_EN, LOAD_PENDING, FRAME_DONE);
        end
        for (int c = 0; c <= 41; c++) begin
            int         q;
            logic [3:0] want_dig;
            want_dig = 4'b0000;
            if (c > 0) begin
                q = (c - 1) % FRAME;
                if (q % SLOT >= BLK) want_dig = 4'(1 << (q / SLOT));
            end
            checks++;
            if (SEG_VAL !== 4'hA || DIG_EN !== want_dig || FRAME_DONE !== (c == 40) ||
                LOAD_PENDING !== 1'b0) begin
                errors++;
                $display("FAIL mid_restart c=%0d: seg=%h dig=%b fd=%b pend=%b, required a %b %b 0",
                         c, SEG_VAL, DIG_EN, FRAME_DONE, LOAD_PENDING, want_dig, (c == 40));
            end
            drive_cycle(1'b1, 1'b0, 16'h0, lz_lvl);
        end
    endtask

    task automatic test_random();
        logic        rst_n;
        logic        ld;
        logic [15:0] data;
        for (int n = 0; n < 3000; n++) begin
            checks++;
            if (SEG_VAL !== exp_seg() || DIG_EN !== m_dig || LOAD_PENDING !== m_pending ||
                FRAME_DONE !== m_fd) begin
                errors++;
                $display("FAIL random n=%0d t=%0d: seg=%h dig=%b pend=%b fd=%b, required %h %b %b %b",
                         n, m_t, SEG_VAL, DIG_EN, LOAD_PENDING, FRAME_DONE,
                         exp_seg(), m_dig, m_pending, m_fd);
            end
            rst_n = ($urandom_range(0, 299) != 0);
            ld    = ($urandom_range(0, 5) == 0);
            for (int i = 0; i < N; i++) begin
                data[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            end
            if ($urandom_range(0, 49) == 0) lz_lvl = ~lz_lvl;
            drive_cycle(rst_n, ld, data, lz_lvl);
        end
    endtask

    initial begin
        RSTN    = 1'b0;
        LOAD    = 1'b0;
        DATA_IN = '0;
        LZ_EN   = 1'b0;
        lz_lvl  = 1'b0;
        test_reset();
        test_load_basic();
        test_lz();
        test_no_tear();
        test_frame_end_load();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexes NUM_DIGITS 4-bit digit codes onto the single shared 7SEG decoder (SEG_VAL in, registered SEG out, 1-cycle latency) and drives one-hot digit enables.
- Inserts a blanking interval between digits to prevent ghosting, and supports optional leading-zero suppression.
- Double-buffers host updates so a frame is never torn.
- Sits between the processor output port and the 7SEG decoder/digit drivers.

Parameters:
NUM_DIGITS, 4, digits scanned; range 2..8
PRESCALE, 1000, CLK cycles per digit SHOW phase; minimum 2
BLANK_CYCLES, 16, CLK cycles per BLANK phase; minimum 1

Ports:
CLK  input  1  system clock
RSTN  input  1  system reset, synchronous, active-low
LOAD  input  1  one-cycle strobe; capture DATA_IN
DATA_IN  input  4*NUM_DIGITS  digit codes; [3:0] = digit 0 (rightmost)
LZ_EN  input  1  leading-zero suppression enable (level)
SEG_VAL  output  4  code to 7SEG decoder; 4'hA = blank, 4'hB = minus
DIG_EN  output  NUM_DIGITS  one-hot digit enable, active-high
LOAD_PENDING  output  1  high while a captured value awaits commit
FRAME_DONE  output  1  one-cycle pulse after each completed frame

Behaviour:
- Single clock. Reset is synchronous and active-low (RSTN sampled on the CLK rising edge).
- Reset values:
  - SEG_VAL=4'hA; DIG_EN=0; LOAD_PENDING=0; FRAME_DONE=0.
  - Display buffer = all 4'hA; pending buffer = 0.
  - State=BLANK; digit index=0; phase counter=0.
- Reset mid-operation: all of the above take effect on the next edge. Any pending load is discarded.
- FSM has two states, BLANK and SHOW:
  - BLANK: SEG_VAL=4'hA. Lasts exactly BLANK_CYCLES cycles, then goes to SHOW at the same digit index.
  - SHOW: SEG_VAL=effective code of the current digit. Lasts exactly PRESCALE cycles, then goes to BLANK with index+1, wrapping NUM_DIGITS-1 -> 0.
- Timing:
  - Slot = BLANK_CYCLES+PRESCALE cycles; frame = NUM_DIGITS slots.
  - Scan order is 0,1,...,NUM_DIGITS-1.
  - After reset release, the first SHOW (digit 0) begins BLANK_CYCLES cycles later.
- Decoder alignment:
  - DIG_EN is a registered copy of (state==SHOW && digit not suppressed) decoded one-hot by the index.
  - DIG_EN therefore lags SEG_VAL by exactly 1 cycle, matching the decoder latency.
  - DIG_EN is never multi-hot, and is all-zero in the cycle after every SHOW->BLANK transition.
- Leading-zero suppression (LZ_EN=1):
  - Digit i (i>0) is suppressed when display codes for digits NUM_DIGITS-1..i are all 4'h0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows SEG_VAL=4'hA with its DIG_EN bit held 0.
  - LZ_EN is sampled every cycle; a change takes effect from the next SHOW entry.
- Load/commit:
  - LOAD=1 copies DATA_IN into the pending buffer and sets LOAD_PENDING. A later LOAD before commit overwrites it (newest wins).
  - Frame end is the edge at which SHOW of digit NUM_DIGITS-1 exits.
  - At frame end: if LOAD=1 on that edge, the display buffer takes DATA_IN directly. Otherwise, if LOAD_PENDING, the display buffer takes the pending buffer. In both cases LOAD_PENDING clears.
  - FRAME_DONE is high for the one cycle following frame end, whether or not a commit occurred.
- The display buffer never changes except at frame end. Codes 4'hC..4'hF pass through unchanged; the decoder blanks them.

Test Plan:
(All scenarios: NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, so slot=10 and frame=40 cycles.)
- Reset: hold RSTN=0 for 3 cycles, then release -> SEG_VAL=4'hA and DIG_EN=0000 during reset. Cycles 2..9 after release: SEG_VAL=4'hA; DIG_EN=0001 only in cycles 3..10. First FRAME_DONE 40 cycles after release.
- LOAD DATA_IN=16'h1234, LZ_EN=0 -> LOAD_PENDING=1 until frame end. The next frame shows SEG_VAL 4,3,2,1 for digits 0..3, each for 8 cycles. DIG_EN=0001/0010/0100/1000, each lagging SEG_VAL by 1 cycle with 2-cycle all-zero gaps.
- LZ_EN=1 with 16'h0050 -> digits 3 and 2 have SEG_VAL=4'hA and DIG_EN bit 0; digits 1 and 0 show 5 and 0. With 16'h0000, only digit 0 is enabled, showing 0.
- LOAD 16'h1111 at cycle 5 and 16'h2222 at cycle 20 of a frame -> the current frame is unchanged. The next frame shows only 2,2,2,2; no mixed frame appears.
- LOAD 16'h9876 on the exact frame-end edge while 16'h1111 is pending -> the next frame shows 6,7,8,9. LOAD_PENDING=0 and FRAME_DONE=1 in the following cycle.
- Assert RSTN=0 during SHOW of digit 2 -> next cycle SEG_VAL=4'hA, DIG_EN=0000, LOAD_PENDING=0. After release, the scan restarts at digit 0 with a blank display buffer.
